dram_cycle_tracker: RTL and testbench
=====================================

// Module: dram_cycle_tracker
// PURPOSE
//  Front-end of the C64 DRAM-socket interface: synchronises async _ras/_cas/_we to clock, demultiplexes
//  row (A7..A0) and column (A15..A8) off maddress, and tracks each bus cycle with an FSM. Gives the
//  downstream MMU/RAM-mapping stage a clean 16-bit address, write flag, tag/RAM phase strobes and a phase
//  counter, and classifies RAS-only and CAS-before-RAS refresh cycles so they never reach the mapper.
// PARAMETERS
//  SYNC_STAGES  2   flops per strobe synchroniser (>=2); maddress delayed by the same depth
//  TAG_CYCLES   2   clocks of phase_tag at start of each access before phase_ram
//  WATCHDOG     63  max clocks outside IDLE before abort (6-bit timer)
// PORTS
//  clock        in   1   system clock, >= 8x bus strobe rate
//  reset        in   1   synchronous, active-high
//  maddress     in   8   multiplexed DRAM address, async
//  _ras         in   1   row strobe, active-low, async
//  _cas         in   1   column strobe, active-low, async
//  _we          in   1   write enable, active-low, async
//  address      out  16  {column, row} of current/last access
//  row_valid    out  1   row latched, RAS low
//  cycle_valid  out  1   access in progress (ACCESS state)
//  cycle_we     out  1   access is a write (sampled on ACCESS entry)
//  cycle_start  out  1   1-clock pulse on ACCESS entry
//  cycle_end    out  1   1-clock pulse on ACCESS exit
//  phase_tag    out  1   cycle_valid & ctr < TAG_CYCLES
//  phase_ram    out  1   cycle_valid & ctr >= TAG_CYCLES
//  ctr          out  4   clocks since ACCESS entry, saturates at 15
//  refresh      out  1   1-clock pulse on completion of refresh cycle
//  err_timeout  out  1   1-clock pulse on watchdog abort
//  stats_clear  in   1   clears stat counters (feature only)
//  stat_access  out  16  access count (feature only)
//  stat_refresh out  16  refresh count (feature only)
// BEHAVIOUR
//  - Sync: _ras/_cas/_we through SYNC_STAGES flops; maddress through parallel pipe of equal depth, so the
//    address used is sampled on the same edge as strobe. Bus requirement: maddress hold >= 2 clocks after strobe.
//  - Transitions use synced levels (ras=!_ras_s, cas=!_cas_s). States: HOLD, IDLE, ROW, ACCESS, TAIL.
//  - HOLD: wait; ras==0 -> IDLE. If entered via CBR, refresh pulse on exit. Reset state is HOLD.
//  - IDLE: ras&!cas -> ROW, latch row, row_valid=1. ras&cas (CBR) -> HOLD flagged CBR. !ras&cas ignored.
//  - ROW: cas -> ACCESS, latch column, cycle_we=!_we_s, ctr=0, cycle_start. !ras -> IDLE, refresh pulse (RAS-only).
//  - ACCESS: ctr+1 per clock, sat 15. !ras -> IDLE + cycle_end (wins if !cas same clock); !cas -> TAIL + cycle_end.
//  - TAIL: cas -> ACCESS (new access, same row, new column, cycle_start). !ras -> IDLE.
//  - Latency: cycle_start/row_valid high SYNC_STAGES+1 clocks after first clock edge sampling strobe low.
//  - address holds last value until next latch; row_valid clears on entering IDLE/HOLD.
//  - Watchdog: 6-bit timer counts clocks in ROW/ACCESS/TAIL, cleared in IDLE/HOLD; at WATCHDOG -> err_timeout,
//    cycle_end if in ACCESS, go HOLD (no refresh). Only one of refresh/cycle_end/err_timeout cause per exit.
//  - Reset: all outputs 0, address 0, ctr 0, sync flops 1 (inactive), state HOLD. Reset mid-cycle: no
//    cycle_start until RAS observed high then low again.
// CONFIGURATION
//  DRAM_CYCLE_STATS_EN defined: stat_access +1 per cycle_start, stat_refresh +1 per refresh pulse, 16-bit
//  wrap at 0xFFFF->0; stats_clear zeroes both (clear wins over same-clock increment); reset zeroes.
//  Undefined: counters not built, stat_access/stat_refresh tied 0, stats_clear ignored.
// TESTING
//  - Read: row 0x34, col 0x12, _we=1, CAS held 6 clocks -> address=0x1234, cycle_we=0, phase_tag 2 clks, ctr 0..5.
//  - Write then RAS-only refresh row 0x7F -> one cycle_start with cycle_we=1; then refresh=1, no cycle_start.
//  - CBR: _cas low before _ras low -> no row_valid, refresh pulse after RAS rise; stat_refresh +1.
//  - Page: RAS low, CAS pulses cols 0x10,0x11 -> two cycle_start, addresses 0x10rr,0x11rr, row unchanged.
//  - Stuck RAS low 80 clocks after CAS -> err_timeout at timer=63, HOLD until RAS high, no refresh.
//  - Reset asserted mid-ACCESS -> outputs 0 next clock; no cycle_start until RAS rises and falls again.

Source files
------------

// File: rtl/dram_cycle_tracker.sv
// C64 DRAM-socket front end: strobe synchronisers, row/column demux and bus-cycle FSM.
// Optional statistics counters are built when DRAM_CYCLE_STATS_EN is defined.
module dram_cycle_tracker #(
  parameter int SYNC_STAGES = 2,
  parameter int TAG_CYCLES  = 2,
  parameter int WATCHDOG    = 63
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  maddress,
  input  logic        _ras,
  input  logic        _cas,
  input  logic        _we,
  output logic [15:0] address,
  output logic        row_valid,
  output logic        cycle_valid,
  output logic        cycle_we,
  output logic        cycle_start,
  output logic        cycle_end,
  output logic        phase_tag,
  output logic        phase_ram,
  output logic [3:0]  ctr,
  output logic        refresh,
  output logic        err_timeout,
  input  logic        stats_clear,
  output logic [15:0] stat_access,
  output logic [15:0] stat_refresh
);

  typedef enum logic [2:0] {
    S_HOLD   = 3'd0,
    S_IDLE   = 3'd1,
    S_ROW    = 3'd2,
    S_ACCESS = 3'd3,
    S_TAIL   = 3'd4
  } state_t;

  localparam logic [3:0] TAG_LIM = 4'(TAG_CYCLES);
  localparam logic [5:0] WD_LIM  = 6'(WATCHDOG);

  logic [SYNC_STAGES-1:0] ras_n_pipe;
  logic [SYNC_STAGES-1:0] cas_n_pipe;
  logic [SYNC_STAGES-1:0] we_n_pipe;
  logic [SYNC_STAGES-1:0] fill_pipe;
  logic [7:0]             maddr_pipe [SYNC_STAGES];

  logic       ras;
  logic       cas;
  logic       we_n_s;
  logic       primed;
  logic [7:0] maddr_s;

  state_t      state;
  state_t      state_next;
  logic        cbr;
  logic        cbr_next;
  logic [5:0]  wd;
  logic [5:0]  wd_next;
  logic        active;
  logic [15:0] address_next;
  logic        cycle_we_next;
  logic [3:0]  ctr_next;
  logic        cycle_start_next;
  logic        cycle_end_next;
  logic        refresh_next;
  logic        err_next;
  logic        row_valid_next;
  logic        cycle_valid_next;
  logic        phase_tag_next;
  logic        phase_ram_next;

  // Strobes and address travel through equal-depth pipes; fill_pipe marks when real samples reach the end.
  always_ff @(posedge clock) begin
    if (reset) begin
      ras_n_pipe <= '1;
      cas_n_pipe <= '1;
      we_n_pipe  <= '1;
      fill_pipe  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        maddr_pipe[i] <= 8'h00;
      end
    end else begin
      ras_n_pipe    <= {ras_n_pipe[SYNC_STAGES-2:0], _ras};
      cas_n_pipe    <= {cas_n_pipe[SYNC_STAGES-2:0], _cas};
      we_n_pipe     <= {we_n_pipe[SYNC_STAGES-2:0], _we};
      fill_pipe     <= {fill_pipe[SYNC_STAGES-2:0], 1'b1};
      maddr_pipe[0] <= maddress;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        maddr_pipe[i] <= maddr_pipe[i-1];
      end
    end
  end

  assign ras     = ~ras_n_pipe[SYNC_STAGES-1];
  assign cas     = ~cas_n_pipe[SYNC_STAGES-1];
  assign we_n_s  = we_n_pipe[SYNC_STAGES-1];
  assign primed  = fill_pipe[SYNC_STAGES-1];
  assign maddr_s = maddr_pipe[SYNC_STAGES-1];
  assign active  = (state == S_ROW) || (state == S_ACCESS) || (state == S_TAIL);

  // Next-state and next-output decode; every exit raises at most one of refresh/cycle_end/err_timeout cause.
  always_comb begin
    state_next       = state;
    cbr_next         = cbr;
    address_next     = address;
    cycle_we_next    = cycle_we;
    ctr_next         = ctr;
    cycle_start_next = 1'b0;
    cycle_end_next   = 1'b0;
    refresh_next     = 1'b0;
    err_next         = 1'b0;
    if (active) begin
      wd_next = wd + 6'd1;
    end else begin
      wd_next = 6'd0;
    end

    if (active && (wd == WD_LIM)) begin
      state_next     = S_HOLD;
      cbr_next       = 1'b0;
      err_next       = 1'b1;
      cycle_end_next = (state == S_ACCESS);
      ctr_next       = 4'd0;
      wd_next        = 6'd0;
    end else begin
      case (state)
        S_HOLD: begin
          if (!ras && primed) begin
            state_next   = S_IDLE;
            refresh_next = cbr;
            cbr_next     = 1'b0;
          end else begin
            state_next = S_HOLD;
          end
        end
        S_IDLE: begin
          if (ras && cas) begin
            state_next = S_HOLD;
            cbr_next   = 1'b1;
          end else if (ras) begin
            state_next   = S_ROW;
            address_next = {address[15:8], maddr_s};
          end else begin
            state_next = S_IDLE;
          end
        end
        S_ROW: begin
          if (cas) begin
            state_next       = S_ACCESS;
            address_next     = {maddr_s, address[7:0]};
            cycle_we_next    = ~we_n_s;
            ctr_next         = 4'd0;
            cycle_start_next = 1'b1;
          end else if (!ras) begin
            state_next   = S_IDLE;
            refresh_next = 1'b1;
          end else begin
            state_next = S_ROW;
          end
        end
        S_ACCESS: begin
          if (!ras) begin
            state_next     = S_IDLE;
            cycle_end_next = 1'b1;
            ctr_next       = 4'd0;
          end else if (!cas) begin
            state_next     = S_TAIL;
            cycle_end_next = 1'b1;
            ctr_next       = 4'd0;
          end else if (ctr == 4'd15) begin
            ctr_next = 4'd15;
          end else begin
            ctr_next = ctr + 4'd1;
          end
        end
        S_TAIL: begin
          if (!ras) begin
            state_next = S_IDLE;
          end else if (cas) begin
            state_next       = S_ACCESS;
            address_next     = {maddr_s, address[7:0]};
            cycle_we_next    = ~we_n_s;
            ctr_next         = 4'd0;
            cycle_start_next = 1'b1;
          end else begin
            state_next = S_TAIL;
          end
        end
        default: begin
          state_next = S_HOLD;
          cbr_next   = 1'b0;
          ctr_next   = 4'd0;
        end
      endcase
    end

    row_valid_next   = (state_next == S_ROW) || (state_next == S_ACCESS) || (state_next == S_TAIL);
    cycle_valid_next = (state_next == S_ACCESS);
    phase_tag_next   = cycle_valid_next && (ctr_next < TAG_LIM);
    phase_ram_next   = cycle_valid_next && !(ctr_next < TAG_LIM);
  end

  // State register with all bus-facing outputs registered alongside it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_HOLD;
      cbr         <= 1'b0;
      wd          <= 6'd0;
      address     <= 16'h0000;
      row_valid   <= 1'b0;
      cycle_valid <= 1'b0;
      cycle_we    <= 1'b0;
      cycle_start <= 1'b0;
      cycle_end   <= 1'b0;
      phase_tag   <= 1'b0;
      phase_ram   <= 1'b0;
      ctr         <= 4'd0;
      refresh     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_next;
      cbr         <= cbr_next;
      wd          <= wd_next;
      address     <= address_next;
      row_valid   <= row_valid_next;
      cycle_valid <= cycle_valid_next;
      cycle_we    <= cycle_we_next;
      cycle_start <= cycle_start_next;
      cycle_end   <= cycle_end_next;
      phase_tag   <= phase_tag_next;
      phase_ram   <= phase_ram_next;
      ctr         <= ctr_next;
      refresh     <= refresh_next;
      err_timeout <= err_next;
    end
  end

`ifdef DRAM_CYCLE_STATS_EN
  // Wrapping event counters; a clear request beats a same-clock increment.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_access  <= 16'h0000;
      stat_refresh <= 16'h0000;
    end else if (stats_clear) begin
      stat_access  <= 16'h0000;
      stat_refresh <= 16'h0000;
    end else begin
      if (cycle_start) begin
        stat_access <= stat_access + 16'h0001;
      end else begin
        stat_access <= stat_access;
      end
      if (refresh) begin
        stat_refresh <= stat_refresh + 16'h0001;
      end else begin
        stat_refresh <= stat_refresh;
      end
    end
  end
`else
  logic unused_stats_clear;
  assign unused_stats_clear = stats_clear;
  assign stat_access        = 16'h0000;
  assign stat_refresh       = 16'h0000;
`endif

endmodule

// File: tb/tb_dram_cycle_tracker.sv
// Directed bench for dram_cycle_tracker: vector table for read/write/refresh, hand sequences for corner cases.
module tb_dram_cycle_tracker;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  maddress;
  logic        ras_n;
  logic        cas_n;
  logic        we_n;
  logic        stats_clear;
  logic [15:0] address;
  logic        row_valid, cycle_valid, cycle_we, cycle_start, cycle_end;
  logic        phase_tag, phase_ram, refresh, err_timeout;
  logic [3:0]  ctr;
  logic [15:0] stat_access, stat_refresh;

`ifdef DRAM_CYCLE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [8:0] RV = 9'h100, CV = 9'h080, WE = 9'h040, CS = 9'h020, CE = 9'h010;
  localparam logic [8:0] TG = 9'h008, RM = 9'h004, RF = 9'h002, ER = 9'h001;

  dram_cycle_tracker dut (
    .clock(clock), .reset(reset), .maddress(maddress),
    ._ras(ras_n), ._cas(cas_n), ._we(we_n),
    .address(address), .row_valid(row_valid), .cycle_valid(cycle_valid),
    .cycle_we(cycle_we), .cycle_start(cycle_start), .cycle_end(cycle_end),
    .phase_tag(phase_tag), .phase_ram(phase_ram), .ctr(ctr),
    .refresh(refresh), .err_timeout(err_timeout),
    .stats_clear(stats_clear), .stat_access(stat_access), .stat_refresh(stat_refresh)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst, rn, cn, wn;
    logic [7:0]  ma;
    logic [15:0] addr;
    logic [8:0]  fl;
    logic [3:0]  c;
  } vec_t;

  vec_t        tbl[$];
  int          checks = 0;
  int          errors = 0;
  int          n_start, n_end, n_ref, n_err, n_rv, n_rv_fall;
  logic        rv_prev;
  logic [15:0] start_addr[$];
  int          exp_acc = 0;
  int          exp_ref = 0;

  function automatic void add(input logic rst, rn, cn, wn, input logic [7:0] ma,
                              input logic [15:0] addr, input logic [8:0] fl, input logic [3:0] c);
    vec_t v;
    v.rst = rst; v.rn = rn; v.cn = cn; v.wn = wn; v.ma = ma; v.addr = addr; v.fl = fl; v.c = c;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    if (cycle_start) begin
      n_start++;
      start_addr.push_back(address);
    end
    if (cycle_end) n_end++;
    if (refresh) n_ref++;
    if (err_timeout) n_err++;
    if (row_valid) n_rv++;
    if (rv_prev && !row_valid) n_rv_fall++;
    rv_prev = row_valid;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_mon();
    n_start = 0; n_end = 0; n_ref = 0; n_err = 0; n_rv = 0; n_rv_fall = 0;
    start_addr.delete();
    rv_prev = row_valid;
  endtask

  task automatic check_stats(input string name);
    check({name, "_acc"}, 64'(stat_access), STATS ? 64'(exp_acc) : 64'd0);
    check({name, "_ref"}, 64'(stat_refresh), STATS ? 64'(exp_ref) : 64'd0);
  endtask

  initial begin
    int t_rv, t_err;
    logic [3:0] ctr_last, ctr_at;

    reset = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1; maddress = 8'h00; stats_clear = 1'b0;

    // Read row 0x34 / col 0x12, CAS low 6 vectors; outputs trail inputs by two vectors.
    add(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 16'h0000, 9'h000, 4'd0);
    add(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 16'h0000, 9'h000, 4'd0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 16'h0000, 9'h000, 4'd0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 16'h0000, 9'h000, 4'd0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 8'h34, 16'h0000, 9'h000, 4'd0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 8'h34, 16'h0000, 9'h000, 4'd0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 8'h12, 16'h0034, RV, 4'd0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 16'h0034, RV, 4'd0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 16'h0034, RV, 4'd0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 16'h1234, RV | CV | CS | TG, 4'd0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 16'h1234, RV | CV | TG, 4'd1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 16'h1234, RV | CV | RM, 4'd2);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 16'h1234, RV | CV | RM, 4'd3);
    add(1'b0, 1'b0, 1'b1, 1'b1, 8'h12, 16'h1234, RV | CV | RM, 4'd4);
    add(1'b0, 1'b0, 1'b1, 1'b1, 8'h12, 16'h1234, RV | CV | RM, 4'd5);
    add(1'b0, 1'b1, 1'b1, 1'b1, 8'h12, 16'h1234, RV | CE, 4'd0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 8'h12, 16'h1234, RV, 4'd0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 8'h12, 16'h1234, 9'h000, 4'd0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 8'h12, 16'h1234, 9'h000, 4'd0);
    // Write row 0x56 / col 0x9A.
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h56, 16'h1234, 9'h000, 4'd0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h56, 16'h1234, 9'h000, 4'd0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h9A, 16'h1256, RV, 4'd0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 8'h9A, 16'h1256, RV, 4'd0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 8'h9A, 16'h1256, RV, 4'd0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h9A, 16'h9A56, RV | CV | WE | CS | TG, 4'd0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h9A, 16'h9A56, RV | CV | WE | TG, 4'd1);
    add(1'b0, 1'b1, 1'b1, 1'b1, 8'h9A, 16'h9A56, RV | WE | CE, 4'd0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 8'h9A, 16'h9A56, RV | WE, 4'd0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 8'h9A, 16'h9A56, WE, 4'd0);
    // RAS-only refresh of row 0x7F: row latched, refresh pulse, no cycle_start.
    add(1'b0, 1'b0, 1'b1, 1'b1, 8'h7F, 16'h9A56, WE, 4'd0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 8'h7F, 16'h9A56, WE, 4'd0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 8'h7F, 16'h9A7F, RV | WE, 4'd0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 8'h7F, 16'h9A7F, RV | WE, 4'd0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 8'h7F, 16'h9A7F, WE | RF, 4'd0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 8'h7F, 16'h9A7F, WE, 4'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; ras_n = tbl[i].rn; cas_n = tbl[i].cn; we_n = tbl[i].wn; maddress = tbl[i].ma;
      step();
      check($sformatf("vec%0d", i),
            64'({address, row_valid, cycle_valid, cycle_we, cycle_start, cycle_end,
                 phase_tag, phase_ram, refresh, err_timeout, ctr}),
            64'({tbl[i].addr, tbl[i].fl, tbl[i].c}));
    end
    exp_acc = 2; exp_ref = 1;
    check_stats("stats_table");

    // CBR: CAS before RAS gives no row, one refresh after RAS rises.
    clear_mon();
    cas_n = 1'b0; steps(3);
    ras_n = 1'b0; steps(4);
    ras_n = 1'b1; steps(4);
    cas_n = 1'b1; steps(4);
    check("cbr_refresh", 64'(n_ref), 64'd1);
    check("cbr_no_start", 64'(n_start), 64'd0);
    check("cbr_no_row", 64'(n_rv), 64'd0);
    exp_ref = 2;
    check_stats("stats_cbr");

    // Page mode: one row 0x21, columns 0x10 and 0x11.
    clear_mon();
    ras_n = 1'b0; maddress = 8'h21; steps(2);
    maddress = 8'h10; steps(1);
    cas_n = 1'b0; steps(3);
    cas_n = 1'b1; maddress = 8'h11; steps(3);
    cas_n = 1'b0; steps(3);
    cas_n = 1'b1; steps(3);
    ras_n = 1'b1; steps(4);
    check("page_starts", 64'(n_start), 64'd2);
    check("page_addr0", 64'(start_addr.size() > 0 ? start_addr[0] : 16'hFFFF), 64'h1021);
    check("page_addr1", 64'(start_addr.size() > 1 ? start_addr[1] : 16'hFFFF), 64'h1121);
    check("page_ends", 64'(n_end), 64'd2);
    check("page_row_kept", 64'(n_rv_fall), 64'd1);
    check("page_no_refresh", 64'(n_ref), 64'd0);
    exp_acc = 4;

    // Stuck RAS/CAS low: abort 64 clocks after ROW entry, then HOLD without refresh.
    clear_mon();
    t_rv = -1; t_err = -1; ctr_last = 4'd0; ctr_at = 4'd0;
    ras_n = 1'b0; maddress = 8'h05;
    for (int i = 0; i < 82; i++) begin
      if (i == 2) begin
        maddress = 8'h06; cas_n = 1'b0;
      end
      step();
      if (row_valid && (t_rv < 0)) t_rv = i;
      if (err_timeout) begin
        t_err = i; ctr_at = ctr_last;
      end
      ctr_last = ctr;
    end
    check("wd_delay", 64'(t_err - t_rv), 64'd64);
    check("wd_err_count", 64'(n_err), 64'd1);
    check("wd_cycle_end", 64'(n_end), 64'd1);
    check("wd_ctr_sat", 64'(ctr_at), 64'd15);
    check("wd_hold_outputs", 64'({row_valid, cycle_valid}), 64'd0);
    ras_n = 1'b1; cas_n = 1'b1; steps(5);
    check("wd_no_refresh", 64'(n_ref), 64'd0);
    check("wd_one_start", 64'(n_start), 64'd1);
    exp_acc = 5;
    check_stats("stats_wd");

    stats_clear = 1'b1; step();
    stats_clear = 1'b0; step();
    exp_acc = 0; exp_ref = 0;
    check_stats("stats_clear");

    // Reset in the middle of an access, with RAS/CAS still low afterwards.
    clear_mon();
    ras_n = 1'b0; maddress = 8'h40; steps(2);
    maddress = 8'h41; cas_n = 1'b0; steps(4);
    check("mid_in_access", 64'(cycle_valid), 64'd1);
    reset = 1'b1; step();
    check("mid_reset_outputs",
          64'({address, row_valid, cycle_valid, cycle_we, cycle_start, cycle_end,
               phase_tag, phase_ram, refresh, err_timeout, ctr}), 64'd0);
    reset = 1'b0;
    clear_mon();
    steps(8);
    check("mid_no_start", 64'(n_start), 64'd0);
    check("mid_no_row", 64'(n_rv), 64'd0);
    ras_n = 1'b1; cas_n = 1'b1; steps(4);
    ras_n = 1'b0; maddress = 8'h50; steps(2);
    maddress = 8'h51; cas_n = 1'b0; steps(4);
    check("mid_restart", 64'(n_start), 64'd1);
    check("mid_restart_addr", 64'(start_addr.size() > 0 ? start_addr[0] : 16'hFFFF), 64'h5150);
    ras_n = 1'b1; cas_n = 1'b1; steps(5);
    exp_acc = 1;
    check_stats("stats_mid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
